// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
// Ports: dmem_req/dmem_we/dmem_addr/dmem_wdata flow stage -> memory,
//        dmem_rdata/dmem_ack flow memory -> stage.
interface mem_wb_stage_if;
    logic        dmem_req;    // access request, held until ack
    logic        dmem_we;     // 1 = store, 0 = load
    logic [31:0] dmem_addr;   // word-aligned byte address
    logic [31:0] dmem_wdata;  // store data
    logic [31:0] dmem_rdata;  // load data, valid with dmem_ack
    logic        dmem_ack;    // one-cycle completion strobe

    // Pipeline stage side.
    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    // Data memory side.
    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Purpose: memory-access stage plus MEM/WB pipeline register (word loads/stores).
// Latency: 1 cycle for non-memory ops; 2 + (req-to-ack wait) cycles for loads/stores.
// Backpressure: mem_stall (combinational) freezes upstream while an access is outstanding.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   MWREG/MM2REG/MWMEM       EX/MEM control flags (reg write, load, store)
//   DATA_MEM_A/_WD           ALU result (memory byte address) and store data
//   MEM_REG_ADDR             destination register, passed through in full
//   mem                      data-memory req/ack port (master side)
//   mem_stall                upstream freeze
//   WWREG/WM2REG/WB_*        registered write-back controls and data
//   mem_fault/mem_fault_code registered fault pulse: 01 misaligned, 10 timeout
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MWREG,
    input  logic                  MM2REG,
    input  logic                  MWMEM,
    input  logic [31:0]           DATA_MEM_A,
    input  logic [31:0]           DATA_MEM_WD,
    input  logic [31:0]           MEM_REG_ADDR,
    mem_wb_stage_if.master        mem,
    output logic                  mem_stall,
    output logic                  WWREG,
    output logic                  WM2REG,
    output logic [31:0]           WB_ALU_RES,
    output logic [31:0]           WB_MEM_DATA,
    output logic [31:0]           WB_REG_ADDR,
    output logic                  mem_fault,
    output logic [1:0]            mem_fault_code
);

    // A zero-width counter is not legal, so TIMEOUT=0 still gets one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // MEM/WB register contents; an all-zero value is a bubble.
    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] alu_res;
        logic [31:0] mem_data;
        logic [31:0] reg_addr;
    } wb_t;

    // Operation captured on acceptance and replayed to memory during WAIT.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        wreg;
        logic        m2reg;
        logic [31:0] reg_addr;
    } op_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    op_t           lat;
    wb_t           wb_q, wb_nxt;
    logic          fault_nxt;
    logic [1:0]    code_nxt;
    logic          take_op;
    logic          stall;

    logic mem_op;
    logic aligned;
    logic timeout_hit;

    assign mem_op  = MM2REG | MWMEM;
    assign aligned = (DATA_MEM_A[1:0] == 2'b00);

    // Abort on the last permitted WAIT cycle so dmem_req is high exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State, counter, latch and MEM/WB registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            lat            <= '0;
            wb_q           <= '0;
            mem_fault      <= 1'b0;
            mem_fault_code <= FAULT_NONE;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            wb_q           <= wb_nxt;
            mem_fault      <= fault_nxt;
            mem_fault_code <= code_nxt;
            if (take_op) begin
                lat.addr     <= DATA_MEM_A;
                lat.wdata    <= DATA_MEM_WD;
                // Both MM2REG and MWMEM set is resolved as a store.
                lat.we       <= MWMEM;
                lat.wreg     <= MWREG;
                lat.m2reg    <= MM2REG;
                lat.reg_addr <= MEM_REG_ADDR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, stall and MEM/WB next value
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wb_nxt    = '0;
        fault_nxt = 1'b0;
        code_nxt  = FAULT_NONE;
        take_op   = 1'b0;
        stall     = 1'b0;

        case (state)
            IDLE: begin
                if (!mem_op) begin
                    wb_nxt.wreg     = MWREG;
                    wb_nxt.alu_res  = DATA_MEM_A;
                    wb_nxt.reg_addr = MEM_REG_ADDR;
                end else if (!aligned) begin
                    // Dropped without touching memory; bubble goes down the pipe.
                    fault_nxt = 1'b1;
                    code_nxt  = FAULT_MISALIGN;
                end else begin
                    stall     = 1'b1;
                    take_op   = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end

            WAIT: begin
                if (mem.dmem_ack) begin
                    // Stall drops here so upstream advances on the capture edge.
                    wb_nxt.wreg     = lat.wreg;
                    wb_nxt.m2reg    = lat.m2reg;
                    wb_nxt.alu_res  = lat.addr;
                    wb_nxt.mem_data = lat.we ? 32'h0 : mem.dmem_rdata;
                    wb_nxt.reg_addr = lat.reg_addr;
                    state_nxt       = IDLE;
                end else if (timeout_hit) begin
                    fault_nxt = 1'b1;
                    code_nxt  = FAULT_TIMEOUT;
                    state_nxt = IDLE;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Request is a pure state decode so reset withdraws it immediately.
    assign mem.dmem_req   = (state == WAIT);
    assign mem.dmem_we    = lat.we;
    assign mem.dmem_addr  = {lat.addr[31:2], 2'b00};
    assign mem.dmem_wdata = lat.wdata;

    assign mem_stall   = stall;
    assign WWREG       = wb_q.wreg;
    assign WM2REG      = wb_q.m2reg;
    assign WB_ALU_RES  = wb_q.alu_res;
    assign WB_MEM_DATA = wb_q.mem_data;
    assign WB_REG_ADDR = wb_q.reg_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU pass-through, load/store with
// variable ack latency, misalignment, timeout and reset during an access.
module tb_mem_wb_stage;
    logic        clk;
    logic        rst;
    logic        MWREG, MM2REG, MWMEM;
    logic [31:0] DATA_MEM_A, DATA_MEM_WD, MEM_REG_ADDR;
    logic        mem_stall, WWREG, WM2REG, mem_fault;
    logic [31:0] WB_ALU_RES, WB_MEM_DATA, WB_REG_ADDR;
    logic [1:0]  mem_fault_code;

    int vecs = 0;
    int errs = 0;

    mem_wb_stage_if mif ();

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .MWREG          (MWREG),
        .MM2REG         (MM2REG),
        .MWMEM          (MWMEM),
        .DATA_MEM_A     (DATA_MEM_A),
        .DATA_MEM_WD    (DATA_MEM_WD),
        .MEM_REG_ADDR   (MEM_REG_ADDR),
        .mem            (mif),
        .mem_stall      (mem_stall),
        .WWREG          (WWREG),
        .WM2REG         (WM2REG),
        .WB_ALU_RES     (WB_ALU_RES),
        .WB_MEM_DATA    (WB_MEM_DATA),
        .WB_REG_ADDR    (WB_REG_ADDR),
        .mem_fault      (mem_fault),
        .mem_fault_code (mem_fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop;
        MWREG = 0; MM2REG = 0; MWMEM = 0;
        DATA_MEM_A = 0; DATA_MEM_WD = 0; MEM_REG_ADDR = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_nop();
        mif.dmem_ack = 0; mif.dmem_rdata = 0;
        #3;
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b want 0", mif.dmem_req); end
        vecs++; if ({WWREG, WM2REG, WB_ALU_RES, WB_MEM_DATA, WB_REG_ADDR} !== 98'h0) begin errs++; $display("FAIL reset_wb: got %b %b %h %h %h want all 0", WWREG, WM2REG, WB_ALU_RES, WB_MEM_DATA, WB_REG_ADDR); end
        vecs++; if ({mem_fault, mem_fault_code} !== 3'b000) begin errs++; $display("FAIL reset_fault: got %b/%b want 0/00", mem_fault, mem_fault_code); end
        vecs++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
        #4 rst = 1'b0;
        tick();
    endtask

    task automatic test_alu;
        MWREG = 1; DATA_MEM_A = 32'h0000_1234; MEM_REG_ADDR = 32'd5;
        #1;
        vecs++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
        tick();
        set_nop();
        vecs++; if (WWREG !== 1'b1 || WM2REG !== 1'b0) begin errs++; $display("FAIL alu_ctl: got %b%b want 10", WWREG, WM2REG); end
        vecs++; if (WB_ALU_RES !== 32'h1234 || WB_REG_ADDR !== 32'd5 || WB_MEM_DATA !== 32'h0) begin errs++; $display("FAIL alu_data: got %h/%h/%h want 1234/5/0", WB_ALU_RES, WB_REG_ADDR, WB_MEM_DATA); end
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL alu_req: got %b want 0", mif.dmem_req); end
    endtask

    task automatic test_load;
        int stalls;
        stalls = 0;
        MWREG = 1; MM2REG = 1; DATA_MEM_A = 32'h100; MEM_REG_ADDR = 32'd7;
        #1;
        if (mem_stall === 1'b1) stalls++;
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL load_accept_req: got %b want 0", mif.dmem_req); end
        tick();
        // Inputs are ignored during WAIT; change them to expose any leak.
        DATA_MEM_A = 32'hFFF0; MEM_REG_ADDR = 32'd30; MWREG = 0; MM2REG = 0;
        for (int k = 1; k <= 3; k++) begin
            vecs++;
            if (mif.dmem_req !== 1'b1 || mif.dmem_addr !== 32'h100 || mif.dmem_we !== 1'b0) begin
                errs++; $display("FAIL load_req_cyc%0d: got req=%b addr=%h we=%b want 1/100/0", k, mif.dmem_req, mif.dmem_addr, mif.dmem_we);
            end
            if (k == 3) begin mif.dmem_ack = 1; mif.dmem_rdata = 32'hDEADBEEF; end
            #1;
            if (mem_stall === 1'b1) stalls++;
            if (k == 3) set_nop();
            tick();
            mif.dmem_ack = 0; mif.dmem_rdata = 0;
        end
        vecs++; if (stalls != 3) begin errs++; $display("FAIL load_stall_cycles: got %0d want 3", stalls); end
        vecs++; if (WWREG !== 1'b1 || WM2REG !== 1'b1) begin errs++; $display("FAIL load_ctl: got %b%b want 11", WWREG, WM2REG); end
        vecs++; if (WB_MEM_DATA !== 32'hDEADBEEF || WB_ALU_RES !== 32'h100 || WB_REG_ADDR !== 32'd7) begin errs++; $display("FAIL load_data: got %h/%h/%h want deadbeef/100/7", WB_MEM_DATA, WB_ALU_RES, WB_REG_ADDR); end
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL load_req_after: got %b want 0", mif.dmem_req); end
    endtask

    task automatic test_store;
        int stalls;
        stalls = 0;
        MWMEM = 1; DATA_MEM_A = 32'h200; DATA_MEM_WD = 32'hCAFEF00D; MEM_REG_ADDR = 32'd9;
        #1;
        if (mem_stall === 1'b1) stalls++;
        tick();
        set_nop();
        vecs++;
        if (mif.dmem_req !== 1'b1 || mif.dmem_we !== 1'b1 || mif.dmem_wdata !== 32'hCAFEF00D || mif.dmem_addr !== 32'h200) begin
            errs++; $display("FAIL store_req: got req=%b we=%b wd=%h a=%h want 1/1/cafef00d/200", mif.dmem_req, mif.dmem_we, mif.dmem_wdata, mif.dmem_addr);
        end
        mif.dmem_ack = 1; mif.dmem_rdata = 32'h5555_AAAA;
        #1;
        if (mem_stall === 1'b1) stalls++;
        tick();
        mif.dmem_ack = 0; mif.dmem_rdata = 0;
        vecs++; if (stalls != 1) begin errs++; $display("FAIL store_stall_cycles: got %0d want 1", stalls); end
        vecs++; if (WWREG !== 1'b0 || WM2REG !== 1'b0 || WB_MEM_DATA !== 32'h0) begin errs++; $display("FAIL store_wb: got %b%b %h want 00 0", WWREG, WM2REG, WB_MEM_DATA); end
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL store_req_one_cycle: got %b want 0", mif.dmem_req); end
    endtask

    // Both load and store flags set, with MWREG: resolves to a store, WM2REG passes through,
    // register written with the ALU result and no memory data.
    task automatic test_store_both_flags;
        MWREG = 1; MM2REG = 1; MWMEM = 1; DATA_MEM_A = 32'h300; DATA_MEM_WD = 32'h1111_2222; MEM_REG_ADDR = 32'd12;
        tick();
        set_nop();
        vecs++; if (mif.dmem_we !== 1'b1) begin errs++; $display("FAIL both_we: got %b want 1", mif.dmem_we); end
        mif.dmem_ack = 1; mif.dmem_rdata = 32'h9999_9999;
        tick();
        mif.dmem_ack = 0; mif.dmem_rdata = 0;
        vecs++; if (WWREG !== 1'b1 || WM2REG !== 1'b1 || WB_MEM_DATA !== 32'h0 || WB_ALU_RES !== 32'h300) begin errs++; $display("FAIL both_wb: got %b%b %h %h want 11 0 300", WWREG, WM2REG, WB_MEM_DATA, WB_ALU_RES); end
        vecs++; if (mem_fault !== 1'b0) begin errs++; $display("FAIL both_fault: got %b want 0", mem_fault); end
    endtask

    task automatic test_misaligned;
        MWREG = 1; MM2REG = 1; DATA_MEM_A = 32'h102; MEM_REG_ADDR = 32'd4;
        #1;
        vecs++; if (mem_stall !== 1'b0 || mif.dmem_req !== 1'b0) begin errs++; $display("FAIL mis_stall_req: got %b/%b want 0/0", mem_stall, mif.dmem_req); end
        tick();
        set_nop();
        vecs++; if (mem_fault !== 1'b1 || mem_fault_code !== 2'b01) begin errs++; $display("FAIL mis_fault: got %b/%b want 1/01", mem_fault, mem_fault_code); end
        vecs++; if (WWREG !== 1'b0 || WB_ALU_RES !== 32'h0 || WB_REG_ADDR !== 32'h0 || mif.dmem_req !== 1'b0) begin errs++; $display("FAIL mis_bubble: got %b %h %h req=%b want 0 0 0 0", WWREG, WB_ALU_RES, WB_REG_ADDR, mif.dmem_req); end
        tick();
        vecs++; if (mem_fault !== 1'b0 || mem_fault_code !== 2'b00) begin errs++; $display("FAIL mis_pulse: got %b/%b want 0/00", mem_fault, mem_fault_code); end
    endtask

    task automatic test_timeout;
        int reqs;
        logic last_stall;
        reqs = 0;
        last_stall = 1'b1;
        MWREG = 1; MM2REG = 1; DATA_MEM_A = 32'h400; MEM_REG_ADDR = 32'd8;
        tick();
        set_nop();
        for (int k = 0; k < 10; k++) begin
            if (mif.dmem_req !== 1'b1) break;
            reqs++;
            #1 last_stall = mem_stall;
            tick();
        end
        vecs++; if (reqs != 4) begin errs++; $display("FAIL to_req_cycles: got %0d want 4", reqs); end
        vecs++; if (last_stall !== 1'b0) begin errs++; $display("FAIL to_stall_release: got %b want 0", last_stall); end
        vecs++; if (mem_fault !== 1'b1 || mem_fault_code !== 2'b10) begin errs++; $display("FAIL to_fault: got %b/%b want 1/10", mem_fault, mem_fault_code); end
        vecs++; if (WWREG !== 1'b0 || WM2REG !== 1'b0 || WB_REG_ADDR !== 32'h0) begin errs++; $display("FAIL to_bubble: got %b%b %h want 00 0", WWREG, WM2REG, WB_REG_ADDR); end
        // Late ack arrives in IDLE and must be ignored.
        mif.dmem_ack = 1; mif.dmem_rdata = 32'h7777_7777;
        tick();
        mif.dmem_ack = 0; mif.dmem_rdata = 0;
        vecs++; if (WWREG !== 1'b0 || WM2REG !== 1'b0 || WB_MEM_DATA !== 32'h0 || mem_fault !== 1'b0 || mem_fault_code !== 2'b00) begin errs++; $display("FAIL to_spurious_ack: got %b%b %h %b/%b want 00 0 0/00", WWREG, WM2REG, WB_MEM_DATA, mem_fault, mem_fault_code); end
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL to_req_idle: got %b want 0", mif.dmem_req); end
    endtask

    task automatic test_reset_mid_wait;
        MWREG = 1; MM2REG = 1; DATA_MEM_A = 32'h500; MEM_REG_ADDR = 32'd6;
        tick();
        set_nop();
        vecs++; if (mif.dmem_req !== 1'b1) begin errs++; $display("FAIL rstw_req_before: got %b want 1", mif.dmem_req); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (mif.dmem_req !== 1'b0 || mif.dmem_addr !== 32'h0) begin errs++; $display("FAIL rstw_req_async: got %b %h want 0 0", mif.dmem_req, mif.dmem_addr); end
        vecs++; if (mem_stall !== 1'b0 || mem_fault !== 1'b0 || WWREG !== 1'b0) begin errs++; $display("FAIL rstw_outputs: got %b %b %b want 0 0 0", mem_stall, mem_fault, WWREG); end
        #3 rst = 1'b0;
        tick();
        MWREG = 1; DATA_MEM_A = 32'h55; MEM_REG_ADDR = 32'd3;
        tick();
        set_nop();
        vecs++; if (WWREG !== 1'b1 || WB_ALU_RES !== 32'h55 || WB_REG_ADDR !== 32'd3 || mem_fault !== 1'b0) begin errs++; $display("FAIL rstw_idle_after: got %b %h %h %b want 1 55 3 0", WWREG, WB_ALU_RES, WB_REG_ADDR, mem_fault); end
        vecs++; if (mif.dmem_req !== 1'b0) begin errs++; $display("FAIL rstw_req_after: got %b want 0", mif.dmem_req); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_store_both_flags();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage pipeline. Consumes the EX/MEM register outputs (write-enable, mem-to-reg, mem-write flags, ALU result as address, store data, destination register), performs word loads/stores over a req/ack data-memory port with variable latency, and registers the result for write-back. Stalls the upstream pipeline while an access is outstanding. Misaligned addresses and ack timeouts are reported as faults.

## Interface
- TIMEOUT, 16: cycles in WAIT without ack before abort; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- MWREG  in  1  instruction writes the register file.
- MM2REG  in  1  load: write-back value comes from memory.
- MWMEM  in  1  store.
- DATA_MEM_A  in  32  ALU result / memory byte address.
- DATA_MEM_WD  in  32  store data.
- MEM_REG_ADDR  in  32  destination register; only [4:0] is significant, all 32 bits passed through.
- dmem_req  out  1  access request, held until ack.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word-aligned byte address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid when dmem_ack = 1.
- dmem_ack  in  1  one-cycle completion strobe.
- mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- WWREG, WM2REG  out  1 each  registered write-back controls.
- WB_ALU_RES, WB_MEM_DATA, WB_REG_ADDR  out  32 each  registered write-back data.
- mem_fault  out  1  registered one-cycle fault pulse.
- mem_fault_code  out  2  01 misaligned, 10 timeout; valid when mem_fault = 1, else 00.

## Operation
- States: IDLE, WAIT. Internal latch holds addr, wdata, we, MWREG, MM2REG, reg addr; timeout counter is $clog2(TIMEOUT+1) bits.
- mem_op = MM2REG | MWMEM. aligned = (DATA_MEM_A[1:0] == 2'b00).
- IDLE, !mem_op: MEM/WB loads WWREG=MWREG, WM2REG=0, WB_ALU_RES=DATA_MEM_A, WB_MEM_DATA=0, WB_REG_ADDR=MEM_REG_ADDR. No stall.
- IDLE, mem_op & !aligned: no access, no stall; MEM/WB loads a bubble (all zeros); mem_fault=1, code 01.
- IDLE, mem_op & aligned: mem_stall=1; inputs latched; MEM/WB loads a bubble; next state WAIT; counter cleared.
- WAIT: dmem_req=1; dmem_addr/we/wdata driven from the latch and stable. Inputs are ignored.
  - ack: MEM/WB loads the latched op (WWREG = latched MWREG, WM2REG = latched MM2REG, WB_MEM_DATA = dmem_rdata for loads, 0 for stores); mem_stall=0 this cycle; next state IDLE.
  - no ack, counter == TIMEOUT-1 (TIMEOUT>0): abort; MEM/WB loads a bubble; mem_fault=1, code 10; mem_stall=0; next state IDLE.
  - otherwise: mem_stall=1, counter increments.
- MM2REG and MWMEM both set: treated as a store; WM2REG passed through. Illegal upstream; no fault.
- dmem_ack outside WAIT is ignored.
- Store with MWREG=1: register write occurs with the ALU result.

## Timing
- Reset (async): state IDLE, counter 0, latch 0. All MEM/WB outputs 0, mem_fault 0, code 00. dmem_req drops immediately.
- Reset during WAIT aborts the access with no fault. The memory side must tolerate a withdrawn request.
- Non-memory op: 1-cycle latency to MEM/WB outputs.
- Load/store: first cycle accepts, dmem_req rises the next cycle. With same-cycle ack, the MEM/WB result appears after the 2nd edge.
- Access latency: 2 + (req-to-ack wait) cycles. mem_stall is high for 1 + wait cycles.
- mem_stall is low in the ack/abort cycle, so upstream advances on the same edge that MEM/WB captures.
- Timeout abort: dmem_req is high exactly TIMEOUT cycles.

## Test plan
- Reset: hold rst mid-WAIT with dmem_req=1 -> dmem_req=0 asynchronously; all outputs 0; after release, state IDLE.
- ALU op: MWREG=1, DATA_MEM_A=0x0000_1234, MEM_REG_ADDR=5 -> next edge: WWREG=1, WB_ALU_RES=0x1234, WB_REG_ADDR=5, mem_stall never high.
- Load with ack after 3 req cycles: A=0x100, MM2REG=1, MWREG=1, rdata=0xDEADBEEF -> mem_stall high 3 cycles; dmem_addr=0x100, dmem_we=0; WB_MEM_DATA=0xDEADBEEF, WM2REG=1 after the ack edge.
- Store with same-cycle ack: A=0x200, WD=0xCAFEF00D -> dmem_we=1, dmem_wdata=0xCAFEF00D for one cycle; WWREG=0; stall exactly 1 cycle.
- Misaligned load A=0x102 -> no dmem_req; mem_fault pulses with code 01; WWREG=0; no stall.
- Timeout, TIMEOUT=4, no ack -> dmem_req high 4 cycles, then mem_fault code 10, bubble written, stall released. A spurious ack one cycle later is ignored.
